// File: rtl/multicycle_ctrl_pkg.sv
// Opcode/funct encodings, ALU functions and datapath select codes for the multicycle controller.
// ILLEGAL_TRAP_EN adds TRAP_VECTOR, the PC value selected by pc_src=PC_SRC_TRAP.
package multicycle_ctrl_pkg;

  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_IMM_ARITH = 7'b0010011;
  localparam logic [6:0] OP_TYPE_S    = 7'b0100011;
  localparam logic [6:0] OP_TYPE_R    = 7'b0110011;
  localparam logic [6:0] OP_TYPE_U    = 7'b0110111;
  localparam logic [6:0] OP_TYPE_SB   = 7'b1100011;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_BREAK     = 7'b1110011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_SRL = 3'b101;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [5:0] F6_BASE = 6'b000000;
  localparam logic [5:0] F6_ALT  = 6'b010000;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_SLL   = 3'd3,
    ALU_SRL   = 3'd4,
    ALU_SRA   = 3'd5,
    ALU_SLT   = 3'd6,
    ALU_PASSB = 3'd7
  } alu_op_t;

  // Instruction class resolved in DECODE; the controller maps it onto its own states.
  typedef enum logic [3:0] {
    DISP_NONE, DISP_R, DISP_I, DISP_LOAD, DISP_STORE,
    DISP_BRANCH, DISP_JAL, DISP_JALR, DISP_LUI, DISP_HALT
  } dispatch_t;

  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_TRAP   = 2'd2;

  localparam logic [1:0] SRC_B_REG  = 2'd0;
  localparam logic [1:0] SRC_B_FOUR = 2'd1;
  localparam logic [1:0] SRC_B_IMM  = 2'd2;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_LINK   = 2'd2;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

`ifdef ILLEGAL_TRAP_EN
  localparam logic [63:0] TRAP_VECTOR = 64'h0000_0000_0000_0100;
`endif

endpackage

// File: rtl/multicycle_ctrl_instr_class_decode.sv
// Combinational instruction classifier: opcode/funct3/funct7 to dispatch class, ALU function,
// access size, load extension and the illegal-encoding flag.
module instr_class_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output dispatch_t  dispatch,
  output alu_op_t    alu_op,
  output logic [1:0] mem_size,
  output logic       load_unsigned,
  output logic       illegal
);

  logic [5:0] funct6;
  assign funct6 = funct7[6:1];

  always_comb begin
    dispatch      = DISP_NONE;
    alu_op        = ALU_ADD;
    mem_size      = SIZE_B;
    load_unsigned = 1'b0;
    illegal       = 1'b0;
    case (opcode)
      OP_TYPE_R: begin
        dispatch = DISP_R;
        case ({funct7, funct3})
          {F7_BASE, F3_ADD}: alu_op = ALU_ADD;
          {F7_ALT,  F3_ADD}: alu_op = ALU_SUB;
          {F7_BASE, F3_SLL}: alu_op = ALU_SLL;
          {F7_BASE, F3_SLT}: alu_op = ALU_SLT;
          {F7_BASE, F3_AND}: alu_op = ALU_AND;
          default:           illegal = 1'b1;
        endcase
      end
      OP_IMM_ARITH: begin
        dispatch = DISP_I;
        // RV64 shift amounts reach into funct7[0], so shifts are told apart by funct6.
        case (funct3)
          F3_ADD: alu_op = ALU_ADD;
          F3_SLT: alu_op = ALU_SLT;
          F3_SLL: begin
            alu_op  = ALU_SLL;
            illegal = (funct6 != F6_BASE);
          end
          F3_SRL: begin
            if (funct6 == F6_BASE)     alu_op = ALU_SRL;
            else if (funct6 == F6_ALT) alu_op = ALU_SRA;
            else                       illegal = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      OP_LOAD: begin
        dispatch = DISP_LOAD;
        case (funct3)
          F3_D:  mem_size = SIZE_D;
          F3_W:  mem_size = SIZE_W;
          F3_H:  mem_size = SIZE_H;
          F3_BU: begin
            mem_size      = SIZE_B;
            load_unsigned = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      OP_TYPE_S: begin
        dispatch = DISP_STORE;
        case (funct3)
          F3_D:    mem_size = SIZE_D;
          F3_W:    mem_size = SIZE_W;
          F3_H:    mem_size = SIZE_H;
          F3_B:    mem_size = SIZE_B;
          default: illegal = 1'b1;
        endcase
      end
      OP_TYPE_SB: begin
        dispatch = DISP_BRANCH;
        alu_op   = ALU_SUB;
        illegal  = !(funct3 == F3_BEQ || funct3 == F3_BNE ||
                     funct3 == F3_BLT || funct3 == F3_BGE);
      end
      OP_JAL:  dispatch = DISP_JAL;
      OP_JALR: begin
        dispatch = DISP_JALR;
        illegal  = (funct3 != 3'b000);
      end
      OP_TYPE_U: begin
        dispatch = DISP_LUI;
        alu_op   = ALU_PASSB;
      end
      OP_BREAK: dispatch = DISP_HALT;
      default:  illegal = 1'b1;
    endcase
    if (illegal) begin
      dispatch      = DISP_NONE;
      load_unsigned = 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback for the RV64 subset.
// Build option ILLEGAL_TRAP_EN: illegal encodings trap through TRAP instead of acting as a NOP.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       alu_zero,
  input  logic       alu_lt,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic [1:0] mem_size,
  output logic       mem_sel,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       load_unsigned,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output alu_op_t    alu_op,
  output logic [1:0] wb_sel,
  output logic       halted,
  output logic       illegal,
  output logic       epc_write,
  output logic [3:0] dbg_state
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,  DECODE = 4'd1,  EXEC_R = 4'd2,  EXEC_I  = 4'd3,
    ADDR    = 4'd4,  BRANCH = 4'd5,  JAL    = 4'd6,  JALR    = 4'd7,
    LUI     = 4'd8,  WB_ALU = 4'd9,  MEM_RD = 4'd10, MEM_WR  = 4'd11,
    WB_LOAD = 4'd12, HALT   = 4'd13, TRAP   = 4'd14
  } ctrl_state_t;

  ctrl_state_t state, next_state;
  logic        run_q;
  logic        active;
  logic        taken;

  dispatch_t   dec_dispatch;
  alu_op_t     dec_alu_op;
  logic [1:0]  dec_mem_size;
  logic        dec_load_unsigned;
  logic        dec_illegal;

  instr_class_decode u_decode (
    .opcode        (opcode),
    .funct3        (funct3),
    .funct7        (funct7),
    .dispatch      (dec_dispatch),
    .alu_op        (dec_alu_op),
    .mem_size      (dec_mem_size),
    .load_unsigned (dec_load_unsigned),
    .illegal       (dec_illegal)
  );

  // Outputs stay quiet while reset_n is low and for the cycle in which it is first released.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= FETCH;
      run_q <= 1'b0;
    end else begin
      state <= next_state;
      run_q <= 1'b1;
    end
  end

  assign active = reset_n & run_q;

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = alu_zero;
      F3_BNE:  taken = !alu_zero;
      F3_BLT:  taken = alu_lt;
      F3_BGE:  taken = !alu_lt;
      default: taken = 1'b0;
    endcase
  end

  // Memory handshake: mem_req is the valid, mem_ack the ready. Request attributes hold
  // until an edge samples mem_ack=1 with mem_req=1; that edge leaves the state, so the
  // request drops the next cycle. mem_ack with mem_req=0 has no effect.
  always_comb begin
    next_state    = state;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_size      = SIZE_B;
    mem_sel       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    load_unsigned = 1'b0;
    pc_src        = PC_SRC_ALU;
    alu_src_a     = 1'b0;
    alu_src_b     = SRC_B_REG;
    alu_op        = ALU_ADD;
    wb_sel        = WB_ALUOUT;
    halted        = 1'b0;
    illegal       = 1'b0;
    epc_write     = 1'b0;
    dbg_state     = 4'd0;
    if (active) begin
      dbg_state = state;
      case (state)
        FETCH: begin
          mem_req  = 1'b1;
          mem_size = SIZE_W;
          if (mem_ack) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            alu_src_b  = SRC_B_FOUR;
            next_state = DECODE;
          end
        end
        DECODE: begin
          alu_src_b = SRC_B_IMM;
          if (dec_illegal) begin
`ifdef ILLEGAL_TRAP_EN
            next_state = TRAP;
`else
            next_state = FETCH;
`endif
          end else begin
            case (dec_dispatch)
              DISP_R:      next_state = EXEC_R;
              DISP_I:      next_state = EXEC_I;
              DISP_LOAD:   next_state = ADDR;
              DISP_STORE:  next_state = ADDR;
              DISP_BRANCH: next_state = BRANCH;
              DISP_JAL:    next_state = JAL;
              DISP_JALR:   next_state = JALR;
              DISP_LUI:    next_state = LUI;
              DISP_HALT:   next_state = HALT;
              default:     next_state = FETCH;
            endcase
          end
        end
        EXEC_R: begin
          alu_src_a  = 1'b1;
          alu_op     = dec_alu_op;
          next_state = WB_ALU;
        end
        EXEC_I: begin
          alu_src_a  = 1'b1;
          alu_src_b  = SRC_B_IMM;
          alu_op     = dec_alu_op;
          next_state = WB_ALU;
        end
        LUI: begin
          alu_src_b  = SRC_B_IMM;
          alu_op     = ALU_PASSB;
          next_state = WB_ALU;
        end
        WB_ALU: begin
          reg_write  = 1'b1;
          next_state = FETCH;
        end
        ADDR: begin
          alu_src_a     = 1'b1;
          alu_src_b     = SRC_B_IMM;
          load_unsigned = dec_load_unsigned;
          next_state    = (dec_dispatch == DISP_LOAD) ? MEM_RD : MEM_WR;
        end
        MEM_RD: begin
          mem_req       = 1'b1;
          mem_sel       = 1'b1;
          mem_size      = dec_mem_size;
          load_unsigned = dec_load_unsigned;
          if (mem_ack) next_state = WB_LOAD;
        end
        MEM_WR: begin
          mem_req  = 1'b1;
          mem_we   = 1'b1;
          mem_sel  = 1'b1;
          mem_size = dec_mem_size;
          if (mem_ack) next_state = FETCH;
        end
        WB_LOAD: begin
          reg_write     = 1'b1;
          wb_sel        = WB_MDR;
          load_unsigned = dec_load_unsigned;
          next_state    = FETCH;
        end
        BRANCH: begin
          alu_src_a  = 1'b1;
          alu_op     = ALU_SUB;
          pc_write   = taken;
          pc_src     = PC_SRC_ALUOUT;
          next_state = FETCH;
        end
        JAL: begin
          pc_write   = 1'b1;
          pc_src     = PC_SRC_ALUOUT;
          reg_write  = 1'b1;
          wb_sel     = WB_LINK;
          next_state = FETCH;
        end
        JALR: begin
          alu_src_a  = 1'b1;
          alu_src_b  = SRC_B_IMM;
          pc_write   = 1'b1;
          reg_write  = 1'b1;
          wb_sel     = WB_LINK;
          next_state = FETCH;
        end
        HALT: begin
          halted     = 1'b1;
          next_state = HALT;
        end
`ifdef ILLEGAL_TRAP_EN
        TRAP: begin
          epc_write  = 1'b1;
          pc_write   = 1'b1;
          pc_src     = PC_SRC_TRAP;
          illegal    = 1'b1;
          next_state = FETCH;
        end
`endif
        default: next_state = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle output checks and instruction latencies.
// The illegal-instruction step follows the ILLEGAL_TRAP_EN build of the design.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_EXEC_R  = 4'd2;
  localparam logic [3:0] S_EXEC_I  = 4'd3;
  localparam logic [3:0] S_ADDR    = 4'd4;
  localparam logic [3:0] S_BRANCH  = 4'd5;
  localparam logic [3:0] S_JAL     = 4'd6;
  localparam logic [3:0] S_LUI     = 4'd8;
  localparam logic [3:0] S_WB_ALU  = 4'd9;
  localparam logic [3:0] S_MEM_RD  = 4'd10;
  localparam logic [3:0] S_MEM_WR  = 4'd11;
  localparam logic [3:0] S_WB_LOAD = 4'd12;
  localparam logic [3:0] S_HALT    = 4'd13;
  localparam logic [3:0] S_TRAP    = 4'd14;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       alu_zero, alu_lt, mem_ack;
  logic       mem_req, mem_we, mem_sel;
  logic [1:0] mem_size;
  logic       ir_write, pc_write, reg_write, load_unsigned;
  logic [1:0] pc_src, alu_src_b, wb_sel;
  logic       alu_src_a;
  alu_op_t    alu_op;
  logic       halted, illegal, epc_write;
  logic [3:0] dbg_state;
  logic [25:0] all_outs;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int t_start = 0;

  multicycle_ctrl dut (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_sel(mem_sel),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .load_unsigned(load_unsigned), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .wb_sel(wb_sel), .halted(halted),
    .illegal(illegal), .epc_write(epc_write), .dbg_state(dbg_state)
  );

  assign all_outs = {mem_req, mem_we, mem_size, mem_sel, ir_write, pc_write, reg_write,
                     load_unsigned, pc_src, alu_src_a, alu_src_b, alu_op, wb_sel,
                     halted, illegal, epc_write, dbg_state};

  // Clock and cycle stepping: inputs change 2 time units after the rising edge,
  // outputs are sampled 1 unit later.
  always #5 clock = ~clock;

  task automatic tick(input logic ack);
    @(posedge clock);
    #2;
    mem_ack = ack;
    cyc++;
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called in a FETCH cycle: optional wait cycles, then the acknowledged fetch of instr.
  task automatic do_fetch(input logic [31:0] instr, input int waits);
    t_start = cyc;
    for (int i = 0; i < waits; i++) begin
      check("fetch_wait_req", 32'(mem_req), 1);
      check("fetch_wait_ir", 32'(ir_write), 0);
      tick(1'b0);
    end
    mem_ack = 1'b1;
    opcode  = instr[6:0];
    funct3  = instr[14:12];
    funct7  = instr[31:25];
    #1;
    check("fetch_state", 32'(dbg_state), 32'(S_FETCH));
    check("fetch_req", 32'({mem_req, mem_we, mem_sel, mem_size}), 32'({3'b100, SIZE_W}));
    check("fetch_strobes", 32'({ir_write, pc_write, reg_write}), 32'b110);
    check("fetch_pc_inc", 32'({pc_src, alu_src_a, alu_src_b}), 32'({PC_SRC_ALU, 1'b0, SRC_B_FOUR}));
    check("fetch_alu_op", 32'(alu_op), 32'(ALU_ADD));
  endtask

  task automatic expect_decode();
    tick(1'b0);
    check("decode_state", 32'(dbg_state), 32'(S_DECODE));
    check("decode_srcs", 32'({alu_src_a, alu_src_b}), 32'({1'b0, SRC_B_IMM}));
    check("decode_quiet", 32'({mem_req, reg_write, pc_write, ir_write}), 0);
  endtask

  task automatic expect_return(input string tag, input int exp_lat);
    tick(1'b0);
    check({tag, "_back_to_fetch"}, 32'({dbg_state, mem_req, mem_sel}), 32'({S_FETCH, 2'b10}));
    check({tag, "_latency"}, 32'(cyc - t_start), 32'(exp_lat));
  endtask

  task automatic run_branch(input string tag, input logic [31:0] instr,
                            input logic zero, input logic lt, input logic exp_taken);
    do_fetch(instr, 0);
    expect_decode();
    tick(1'b0);
    alu_zero = zero;
    alu_lt   = lt;
    #1;
    check({tag, "_state"}, 32'(dbg_state), 32'(S_BRANCH));
    check({tag, "_alu"}, 32'({alu_op, alu_src_a, alu_src_b}), 32'({ALU_SUB, 1'b1, SRC_B_REG}));
    check({tag, "_pc"}, 32'({pc_write, pc_src, reg_write}), 32'({exp_taken, PC_SRC_ALUOUT, 1'b0}));
    expect_return(tag, 3);
  endtask

  initial begin
    reset_n = 1'b0; mem_ack = 1'b0; alu_zero = 1'b0; alu_lt = 1'b0;
    opcode = '0; funct3 = '0; funct7 = '0;

    // Reset and release
    tick(1'b0);
    check("reset_outs_zero", 32'(all_outs), 0);
    tick(1'b0);
    mem_ack = 1'b1;
    #1;
    check("reset_ack_ignored", 32'(all_outs), 0);
    mem_ack = 1'b0;
    reset_n = 1'b1;
    #1;
    check("release_cycle_quiet", 32'(mem_req), 0);
    tick(1'b0);
    check("first_fetch_req", 32'({dbg_state, mem_req, mem_sel, mem_size}), 32'({S_FETCH, 2'b10, SIZE_W}));

    // add x3,x1,x2
    do_fetch(32'h002081B3, 0);
    expect_decode();
    tick(1'b0);
    check("add_exec", 32'({dbg_state, alu_op, alu_src_a, alu_src_b, reg_write}),
          32'({S_EXEC_R, ALU_ADD, 1'b1, SRC_B_REG, 1'b0}));
    tick(1'b0);
    check("add_wb", 32'({dbg_state, reg_write, wb_sel, mem_req}), 32'({S_WB_ALU, 1'b1, WB_ALUOUT, 1'b0}));
    expect_return("add", 4);
    check("add_no_wb_after", 32'(reg_write), 0);

    // sub x3,x1,x2 with a 2-cycle fetch wait
    do_fetch(32'h402081B3, 2);
    expect_decode();
    tick(1'b0);
    check("sub_alu_op", 32'(alu_op), 32'(ALU_SUB));
    tick(1'b0);
    check("sub_wb", 32'(reg_write), 1);
    expect_return("sub", 6);

    // srai x1,x1,3
    do_fetch(32'h4030D093, 0);
    expect_decode();
    tick(1'b0);
    check("srai_exec", 32'({dbg_state, alu_op, alu_src_a, alu_src_b}),
          32'({S_EXEC_I, ALU_SRA, 1'b1, SRC_B_IMM}));
    tick(1'b0);
    check("srai_wb", 32'({dbg_state, reg_write}), 32'({S_WB_ALU, 1'b1}));
    expect_return("srai", 4);

    // lui x1,1
    do_fetch(32'h000010B7, 0);
    expect_decode();
    tick(1'b0);
    check("lui_exec", 32'({dbg_state, alu_op, alu_src_b}), 32'({S_LUI, ALU_PASSB, SRC_B_IMM}));
    tick(1'b0);
    check("lui_wb", 32'(reg_write), 1);
    expect_return("lui", 4);

    // lw x2,0(x1), data ack after 3 wait cycles
    do_fetch(32'h0000A103, 0);
    expect_decode();
    tick(1'b0);
    check("lw_addr", 32'({dbg_state, alu_src_a, alu_src_b, alu_op, mem_req}),
          32'({S_ADDR, 1'b1, SRC_B_IMM, ALU_ADD, 1'b0}));
    for (int i = 0; i < 4; i++) begin
      tick(i == 3);
      check("lw_req_hold", 32'({dbg_state, mem_req, mem_we, mem_sel, mem_size}),
            32'({S_MEM_RD, 3'b101, SIZE_W}));
    end
    tick(1'b0);
    check("lw_wb", 32'({dbg_state, reg_write, wb_sel, mem_req, load_unsigned}),
          32'({S_WB_LOAD, 1'b1, WB_MDR, 2'b00}));
    expect_return("lw", 8);

    // lbu x2,0(x1), zero-wait
    do_fetch(32'h0000C103, 0);
    expect_decode();
    tick(1'b0);
    tick(1'b1);
    check("lbu_req", 32'({mem_req, mem_size, load_unsigned}), 32'({1'b1, SIZE_B, 1'b1}));
    tick(1'b0);
    check("lbu_wb", 32'({reg_write, wb_sel, load_unsigned}), 32'({1'b1, WB_MDR, 1'b1}));
    expect_return("lbu", 5);

    // sd x2,0(x1), zero-wait
    do_fetch(32'h0020B023, 0);
    expect_decode();
    tick(1'b0);
    check("sd_addr", 32'(dbg_state), 32'(S_ADDR));
    tick(1'b1);
    check("sd_req", 32'({dbg_state, mem_req, mem_we, mem_sel, mem_size, reg_write}),
          32'({S_MEM_WR, 3'b111, SIZE_D, 1'b0}));
    expect_return("sd", 4);

    // Branches
    run_branch("beq_taken", 32'h00208063, 1'b1, 1'b0, 1'b1);
    run_branch("beq_not",   32'h00208063, 1'b0, 1'b0, 1'b0);
    run_branch("bge_taken", 32'h0020D063, 1'b0, 1'b0, 1'b1);
    run_branch("bne_taken", 32'h00209063, 1'b0, 1'b1, 1'b1);
    run_branch("blt_not",   32'h0020C063, 1'b1, 1'b0, 1'b0);

    // jal x1,0
    do_fetch(32'h000000EF, 0);
    expect_decode();
    tick(1'b0);
    check("jal_state", 32'({dbg_state, pc_write, pc_src, reg_write, wb_sel}),
          32'({S_JAL, 1'b1, PC_SRC_ALUOUT, 1'b1, WB_LINK}));
    tick(1'b0);
    check("jal_back", 32'(dbg_state), 32'(S_FETCH));

    // Illegal encoding 0x0000007F
    do_fetch(32'h0000007F, 0);
    expect_decode();
    check("illegal_decode_flag", 32'(illegal), 0);
`ifdef ILLEGAL_TRAP_EN
    tick(1'b0);
    check("trap_state", 32'({dbg_state, illegal, epc_write, pc_write, pc_src, reg_write}),
          32'({S_TRAP, 3'b111, PC_SRC_TRAP, 1'b0}));
    expect_return("trap", 3);
    check("trap_pulse_end", 32'({illegal, epc_write}), 0);
`else
    expect_return("illegal_nop", 2);
    check("illegal_nop_flags", 32'({illegal, epc_write, ir_write}), 32'b000);
`endif

    // sw with a pending write abandoned by reset
    do_fetch(32'h0020A023, 0);
    expect_decode();
    tick(1'b0);
    tick(1'b0);
    check("sw_wait", 32'({dbg_state, mem_req, mem_we, mem_sel}), 32'({S_MEM_WR, 3'b111}));
    tick(1'b0);
    reset_n = 1'b0;
    #1;
    check("sw_reset_outs_zero", 32'(all_outs), 0);
    tick(1'b0);
    reset_n = 1'b1;
    #1;
    check("sw_release_quiet", 32'(mem_req), 0);
    tick(1'b0);
    check("sw_refetch", 32'({dbg_state, mem_req, mem_we, mem_sel}), 32'({S_FETCH, 3'b100}));

    // ebreak, hold in HALT, then reset
    do_fetch(32'h00100073, 0);
    expect_decode();
    for (int i = 0; i < 20; i++) begin
      tick(i[0]);
      check("halt_hold", 32'({dbg_state, halted, mem_req, mem_we, ir_write, pc_write, reg_write}),
            32'({S_HALT, 6'b100000}));
    end
    tick(1'b0);
    reset_n = 1'b0;
    #1;
    check("halt_reset_clear", 32'(all_outs), 0);
    tick(1'b0);
    reset_n = 1'b1;
    #1;
    check("halt_release_quiet", 32'({halted, mem_req}), 0);
    tick(1'b0);
    check("halt_resume_fetch", 32'({dbg_state, halted, mem_req, mem_sel}), 32'({S_FETCH, 3'b010}));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
